// File: rtl/mu0_control_pkg.sv
// Shared types and encodings for the MU0 sequencer: FSM states, opcodes, ALU functions,
// mux select values and the packed control word produced by the decoder.
package mu0_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Opcodes 8..F are illegal and send the sequencer to FAULT.
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_Y   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_INC = 2'b11;

  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;
  localparam logic X_ACC   = 1'b0;
  localparam logic X_PC    = 1'b1;
  localparam logic Y_MEM   = 1'b0;
  localparam logic Y_IR    = 1'b1;

  typedef struct packed {
    logic       mem_rq;
    logic       rnw;
    logic       addr_sel;
    logic       x_sel;
    logic       y_sel;
    logic [1:0] alu_fs;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic       acc_oe;
  } ctrl_t;

  // Wait counter must be able to hold TIMEOUT itself; keep at least one bit when disabled.
  function automatic int wait_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mu0_control_if.sv
// Control-side bundle between the MU0 sequencer and its datapath/memory: opcode and flags in,
// memory handshake, mux selects, load enables and status out.
interface mu0_control_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       F;
  logic             N;
  logic             Z;
  logic             MemAck;
  logic             MEMrq;
  logic             RnW;
  logic             Addr_sel;
  logic             X_sel;
  logic             Y_sel;
  logic [1:0]       ALU_fs;
  logic             PC_En;
  logic             IR_En;
  logic             Acc_En;
  logic             Acc_oe;
  logic             Halted;
  logic             Fault;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  F, N, Z, MemAck,
    output MEMrq, RnW, Addr_sel, X_sel, Y_sel, ALU_fs,
           PC_En, IR_En, Acc_En, Acc_oe, Halted, Fault, InstrCount
  );

  modport slave (
    output F, N, Z, MemAck,
    input  MEMrq, RnW, Addr_sel, X_sel, Y_sel, ALU_fs,
           PC_En, IR_En, Acc_En, Acc_oe, Halted, Fault, InstrCount
  );
endinterface

// File: rtl/mu0_control_decode.sv
// Combinational control-word decode from FSM state, opcode, flags and MemAck; zero latency.
// Load enables are Mealy on MemAck so a stalled transfer never commits partial state.
module mu0_control_decode
  import mu0_control_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] f,
  input  logic       n,
  input  logic       z,
  input  logic       mem_ack,
  output ctrl_t      ctrl
);

  logic take;

  always_comb begin
    take = (f == OP_JMP) || ((f == OP_JGE) && !n) || ((f == OP_JNE) && !z);

    ctrl          = '0;
    ctrl.addr_sel = ADDR_PC;
    ctrl.x_sel    = X_ACC;
    ctrl.y_sel    = Y_MEM;
    ctrl.alu_fs   = ALU_Y;

    unique case (state)
      ST_FETCH: begin
        ctrl.mem_rq   = 1'b1;
        ctrl.rnw      = 1'b1;
        ctrl.addr_sel = ADDR_PC;
        if (mem_ack) begin
          ctrl.ir_en  = 1'b1;
          ctrl.pc_en  = 1'b1;
          ctrl.x_sel  = X_PC;
          ctrl.alu_fs = ALU_INC;
        end
      end

      ST_EXEC: begin
        case (f)
          OP_LDA: begin
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b1;
            ctrl.addr_sel = ADDR_IR;
            if (mem_ack) begin
              ctrl.acc_en = 1'b1;
              ctrl.y_sel  = Y_MEM;
              ctrl.alu_fs = ALU_Y;
            end
          end

          OP_STA: begin
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b0;
            ctrl.addr_sel = ADDR_IR;
            ctrl.acc_oe   = 1'b1;
          end

          OP_ADD, OP_SUB: begin
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b1;
            ctrl.addr_sel = ADDR_IR;
            ctrl.x_sel    = X_ACC;
            ctrl.y_sel    = Y_MEM;
            if (mem_ack) begin
              ctrl.acc_en = 1'b1;
              ctrl.alu_fs = (f == OP_ADD) ? ALU_ADD : ALU_SUB;
            end
          end

          // Untaken branches simply fall through to the next fetch with no enables.
          OP_JMP, OP_JGE, OP_JNE: begin
            if (take) begin
              ctrl.pc_en  = 1'b1;
              ctrl.y_sel  = Y_IR;
              ctrl.alu_fs = ALU_Y;
            end
          end

          default: ;
        endcase
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer: 1 IDLE cycle after reset, then fetch+execute (2 cycles + wait states).
// Holds MEMrq until MemAck; faults if no ack within TIMEOUT request cycles (0 disables the timeout).
module mu0_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic          Clk,
  input  logic          nReset,
  mu0_control_if.master bus
);
  import mu0_control_pkg::*;

  localparam int                WAIT_W    = wait_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q;
  state_t           state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  count_q;
  ctrl_t             ctrl;
  logic              ack;
  logic              timeout_hit;

  mu0_control_decode u_decode (
    .state   (state_q),
    .f       (bus.F),
    .n       (bus.N),
    .z       (bus.Z),
    .mem_ack (bus.MemAck),
    .ctrl    (ctrl)
  );

  // An ack arriving on the last allowed request cycle still completes the transfer.
  assign ack         = ctrl.mem_rq & bus.MemAck;
  assign timeout_hit = (TIMEOUT > 0) && ctrl.mem_rq && !bus.MemAck && (wait_q == WAIT_LAST);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (ack) begin
          state_d = ST_EXEC;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end

      ST_EXEC: begin
        if (ctrl.mem_rq) begin
          if (ack) begin
            state_d = ST_FETCH;
          end else if (timeout_hit) begin
            state_d = ST_FAULT;
          end
        end else if (bus.F == OP_STP) begin
          state_d = ST_HALT;
        end else if (bus.F > OP_STP) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_FETCH;
        end
      end

      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wait_q <= '0;
    end else if ((state_d != state_q) || ack) begin
      wait_q <= '0;
    end else if (ctrl.mem_rq && (TIMEOUT > 0)) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count_q <= '0;
    end else if ((state_q == ST_FETCH) && ack) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.MEMrq      = ctrl.mem_rq;
  assign bus.RnW        = ctrl.rnw;
  assign bus.Addr_sel   = ctrl.addr_sel;
  assign bus.X_sel      = ctrl.x_sel;
  assign bus.Y_sel      = ctrl.y_sel;
  assign bus.ALU_fs     = ctrl.alu_fs;
  assign bus.PC_En      = ctrl.pc_en;
  assign bus.IR_En      = ctrl.ir_en;
  assign bus.Acc_En     = ctrl.acc_en;
  assign bus.Acc_oe     = ctrl.acc_oe;
  assign bus.Halted     = (state_q == ST_HALT);
  assign bus.Fault      = (state_q == ST_FAULT);
  assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: per-cycle vector table plus sequences for timeout and reset.
module tb_mu0_control;

  logic Clk    = 1'b0;
  logic nReset = 1'b0;

  mu0_control_if #(.CNT_W(16)) bus ();

  mu0_control #(.TIMEOUT(15), .CNT_W(16)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Output order: MEMrq RnW Addr_sel X_sel Y_sel ALU_fs[1:0] PC_En IR_En Acc_En Acc_oe Halted Fault
  localparam logic [12:0] P_ZERO  = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] P_FWAIT = 13'b1_1_0_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] P_FACK  = 13'b1_1_0_1_0_11_1_1_0_0_0_0;
  localparam logic [12:0] P_RDW   = 13'b1_1_1_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] P_LDA   = 13'b1_1_1_0_0_00_0_0_1_0_0_0;
  localparam logic [12:0] P_STA   = 13'b1_0_1_0_0_00_0_0_0_1_0_0;
  localparam logic [12:0] P_ADD   = 13'b1_1_1_0_0_01_0_0_1_0_0_0;
  localparam logic [12:0] P_SUB   = 13'b1_1_1_0_0_10_0_0_1_0_0_0;
  localparam logic [12:0] P_JMP   = 13'b0_0_0_0_1_00_1_0_0_0_0_0;
  localparam logic [12:0] P_HALT  = 13'b0_0_0_0_0_00_0_0_0_0_1_0;
  localparam logic [12:0] P_FAULT = 13'b0_0_0_0_0_00_0_0_0_0_0_1;

  typedef struct {
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic        ack;
    logic [12:0] exp;
    logic [15:0] cnt;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [12:0] outs();
    return {bus.MEMrq, bus.RnW, bus.Addr_sel, bus.X_sel, bus.Y_sel, bus.ALU_fs,
            bus.PC_En, bus.IR_En, bus.Acc_En, bus.Acc_oe, bus.Halted, bus.Fault};
  endfunction

  task automatic check(input string name, input logic [12:0] exp, input logic [15:0] cnt);
    checks++;
    if (outs() !== exp || bus.InstrCount !== cnt) begin
      failures++;
      $display("FAIL %s: got outs=%b count=%0d, expected outs=%b count=%0d",
               name, outs(), bus.InstrCount, exp, cnt);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic n, input logic z, input logic ack);
    bus.F      = f;
    bus.N      = n;
    bus.Z      = z;
    bus.MemAck = ack;
  endtask

  // One clock cycle: inputs applied at the falling edge, outputs sampled 1 time unit later.
  task automatic cyc(input logic [3:0] f, input logic n, input logic z, input logic ack);
    @(negedge Clk);
    drive(f, n, z, ack);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("in_reset", P_ZERO, 16'd0);
    @(posedge Clk);
    #1;
    nReset = 1'b1;
  endtask

  task automatic add(input logic [3:0] f, input logic n, input logic z, input logic ack,
                     input logic [12:0] exp, input logic [15:0] cnt, input string name);
    vec_t v;
    v.f = f; v.n = n; v.z = z; v.ack = ack; v.exp = exp; v.cnt = cnt; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive(4'd0, 1'b0, 1'b0, 1'b0);

    add(4'd0, 0, 0, 1, P_ZERO,  16'd0,  "idle_ack_ignored");
    add(4'd0, 0, 0, 0, P_FWAIT, 16'd0,  "fetch_wait");
    add(4'd0, 0, 0, 1, P_FACK,  16'd0,  "fetch_lda");
    add(4'd0, 0, 0, 1, P_LDA,   16'd1,  "lda_exec");
    add(4'd1, 0, 0, 1, P_FACK,  16'd1,  "fetch_sta");
    add(4'd1, 0, 0, 0, P_STA,   16'd2,  "sta_wait1");
    add(4'd1, 0, 0, 0, P_STA,   16'd2,  "sta_wait2");
    add(4'd1, 0, 0, 0, P_STA,   16'd2,  "sta_wait3");
    add(4'd1, 0, 0, 1, P_STA,   16'd2,  "sta_ack");
    add(4'd2, 0, 0, 1, P_FACK,  16'd2,  "fetch_add");
    add(4'd2, 0, 0, 0, P_RDW,   16'd3,  "add_wait");
    add(4'd2, 0, 0, 1, P_ADD,   16'd3,  "add_ack");
    add(4'd3, 0, 0, 1, P_FACK,  16'd3,  "fetch_sub");
    add(4'd3, 0, 0, 1, P_SUB,   16'd4,  "sub_ack");
    add(4'd4, 0, 0, 1, P_FACK,  16'd4,  "fetch_jmp");
    add(4'd4, 0, 0, 1, P_JMP,   16'd5,  "jmp_exec");
    add(4'd5, 1, 0, 1, P_FACK,  16'd5,  "fetch_jge_n1");
    add(4'd5, 1, 0, 1, P_ZERO,  16'd6,  "jge_n1_untaken");
    add(4'd5, 0, 0, 1, P_FACK,  16'd6,  "fetch_jge_n0");
    add(4'd5, 0, 0, 1, P_JMP,   16'd7,  "jge_n0_taken");
    add(4'd6, 0, 1, 1, P_FACK,  16'd7,  "fetch_jne_z1");
    add(4'd6, 0, 1, 1, P_ZERO,  16'd8,  "jne_z1_untaken");
    add(4'd6, 0, 0, 1, P_FACK,  16'd8,  "fetch_jne_z0");
    add(4'd6, 0, 0, 1, P_JMP,   16'd9,  "jne_z0_taken");
    add(4'd7, 0, 0, 1, P_FACK,  16'd9,  "fetch_stp");
    add(4'd7, 0, 0, 1, P_ZERO,  16'd10, "stp_exec");
    add(4'd7, 0, 0, 1, P_HALT,  16'd10, "halted");
    add(4'd0, 0, 0, 1, P_HALT,  16'd10, "halt_sticky_lda");
    add(4'd9, 0, 0, 1, P_HALT,  16'd10, "halt_sticky_illegal");

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].f, tbl[i].n, tbl[i].z, tbl[i].ack);
      check(tbl[i].name, tbl[i].exp, tbl[i].cnt);
    end

    // Halted clears only through reset.
    do_reset();

    // Illegal opcode.
    cyc(4'd9, 0, 0, 1); check("ill_idle", P_ZERO, 16'd0);
    cyc(4'd9, 0, 0, 1); check("ill_fetch", P_FACK, 16'd0);
    cyc(4'd9, 0, 0, 1); check("ill_exec", P_ZERO, 16'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'd0, 0, 0, 1); check("ill_fault_sticky", P_FAULT, 16'd1);
    end
    do_reset();

    // Fetch timeout: 15 request cycles without ack, then FAULT.
    cyc(4'd0, 0, 0, 0); check("to_idle", P_ZERO, 16'd0);
    for (int i = 0; i < 15; i++) begin
      cyc(4'd0, 0, 0, 0); check("to_fetch_wait", P_FWAIT, 16'd0);
    end
    cyc(4'd0, 0, 0, 0); check("to_fault", P_FAULT, 16'd0);
    cyc(4'd0, 0, 0, 1); check("to_fault_sticky", P_FAULT, 16'd0);
    do_reset();

    // Ack on the 15th request cycle completes; counter restarts for the next transfer.
    cyc(4'd4, 0, 0, 0); check("lim_idle", P_ZERO, 16'd0);
    for (int i = 0; i < 14; i++) begin
      cyc(4'd4, 0, 0, 0); check("lim_fetch_wait", P_FWAIT, 16'd0);
    end
    cyc(4'd4, 0, 0, 1); check("lim_fetch_ack", P_FACK, 16'd0);
    cyc(4'd4, 0, 0, 1); check("lim_jmp", P_JMP, 16'd1);
    for (int i = 0; i < 14; i++) begin
      cyc(4'd0, 0, 0, 0); check("lim2_fetch_wait", P_FWAIT, 16'd1);
    end
    cyc(4'd0, 0, 0, 1); check("lim2_fetch_ack", P_FACK, 16'd1);
    for (int i = 0; i < 15; i++) begin
      cyc(4'd0, 0, 0, 0); check("exec_lda_wait", P_RDW, 16'd2);
    end
    cyc(4'd0, 0, 0, 1); check("exec_timeout_fault", P_FAULT, 16'd2);
    do_reset();

    // Asynchronous reset in the middle of an ADD wait.
    cyc(4'd2, 0, 0, 0); check("mid_idle", P_ZERO, 16'd0);
    cyc(4'd2, 0, 0, 1); check("mid_fetch", P_FACK, 16'd0);
    cyc(4'd2, 0, 0, 0); check("mid_add_wait1", P_RDW, 16'd1);
    cyc(4'd2, 0, 0, 0); check("mid_add_wait2", P_RDW, 16'd1);
    nReset = 1'b0;
    #1;
    check("mid_async_reset", P_ZERO, 16'd0);
    @(posedge Clk);
    #1;
    nReset = 1'b1;
    cyc(4'd2, 0, 0, 0); check("mid_idle_after", P_ZERO, 16'd0);
    cyc(4'd2, 0, 0, 0); check("mid_fetch_after", P_FWAIT, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
